// File: rtl/buzzer_player_if.sv
// ---------------------------------------------------------------------------
// buzzer_player_if
//   Read-port bundle between the buzzer sequencer and the song-table BRAM.
//
//   Signals:
//     bram_en    read enable, driven by the sequencer
//     bram_addr  read address, driven by the sequencer
//     bram_data  read data, valid one cycle after bram_en
//
//   Modports:
//     master  the sequencer side (drives enable/address, takes data)
//     slave   the BRAM side (takes enable/address, returns data)
// ---------------------------------------------------------------------------
interface buzzer_player_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 12
);
  logic                  bram_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_data;

  modport master (output bram_en, output bram_addr, input  bram_data);
  modport slave  (input  bram_en, input  bram_addr, output bram_data);
endinterface

// File: rtl/buzzer_player.sv
// ---------------------------------------------------------------------------
// buzzer_player
//   Song sequencer sitting in front of the buzzer music BRAM. It walks the
//   song table from address 0, decodes each 12-bit note word and drives a
//   square wave on buzzer_o for the note's duration.
//
//   Note word: [11:9] dur  beats (1..7), 0 = end-of-song marker
//              [8:0]  hp   half-period in ticks, 0 = rest
//
//   Ports:
//     clk       system clock
//     rst       synchronous, active-high reset
//     start     1-cycle pulse, begin playback at address 0 (ignored if busy)
//     stop      1-cycle pulse, abort playback (wins over start)
//     loop_en   level, restart at address 0 at end of song
//     bram      song-table read port (buzzer_player_if.master)
//     buzzer_o  square wave to the buzzer pin
//     busy      high in every state except IDLE
//     done      1-cycle pulse when the song ends without looping
//
//   Optional build macro: BUZZER_PLAYER_GAP_EN
//     When defined, the last GAP_TICKS ticks of each note are forced silent
//     (articulation gap); note length is unchanged.
// ---------------------------------------------------------------------------
module buzzer_player #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 12,
  parameter int TICK_DIV   = 500,
  parameter int BEAT_TICKS = 12500,
  parameter int GAP_TICKS  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  buzzer_player_if.master  bram,
  output logic             buzzer_o,
  output logic             busy,
  output logic             done
);

  localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int BW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_END
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [BW-1:0]   beat_cnt;
  logic [2:0]      beat_left;
  logic [8:0]      half_cnt;
  logic [8:0]      note_hp;

  logic [DATA_WIDTH-1:0] word;
  logic [2:0]            word_dur;
  logic [8:0]            word_hp;
  logic                  tick;
  logic                  last_beat_tick;
  logic [BW-1:0]         beat_cnt_nxt;
  logic                  in_gap;

  assign word     = bram.bram_data;
  assign word_dur = word[11:9];
  assign word_hp  = word[8:0];

  assign tick           = (presc == PW'(TICK_DIV - 1));
  assign last_beat_tick = (beat_cnt == BW'(BEAT_TICKS - 1));
  assign beat_cnt_nxt   = last_beat_tick ? '0 : beat_cnt + BW'(1);

`ifdef BUZZER_PLAYER_GAP_EN
  // Judged on the beat count this tick moves to, so silence starts on the
  // very tick that enters the gap window rather than one tick later.
  assign in_gap = (beat_left == 3'd1) &&
                  (beat_cnt_nxt >= BW'(BEAT_TICKS - GAP_TICKS));
`else
  logic unused_gap_ticks;
  assign in_gap           = 1'b0;
  assign unused_gap_ticks = (GAP_TICKS != 0);
`endif

  // NOTE: every state register is assigned with <= so all of them update
  // together at the edge; where one branch assigns a signal twice (e.g.
  // buzzer_o in PLAY), the later assignment deliberately wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      presc          <= '0;
      beat_cnt       <= '0;
      beat_left      <= '0;
      half_cnt       <= '0;
      note_hp        <= '0;
      bram.bram_en   <= 1'b0;
      bram.bram_addr <= '0;
      buzzer_o       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else if (stop) begin
      state        <= S_IDLE;
      presc        <= '0;
      bram.bram_en <= 1'b0;
      buzzer_o     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done         <= 1'b0;
      bram.bram_en <= 1'b0;
      presc        <= tick ? '0 : presc + PW'(1);

      unique case (state)
        S_IDLE: begin
          presc <= '0;
          if (start) begin
            state          <= S_FETCH;
            bram.bram_addr <= '0;
            bram.bram_en   <= 1'b1;
            busy           <= 1'b1;
          end
        end

        // Read was issued on entry; data lands for LATCH.
        S_FETCH: state <= S_LATCH;

        S_LATCH: begin
          presc   <= '0;
          note_hp <= word_hp;
          if (word_dur == 3'd0) begin
            state <= S_END;
          end else begin
            state     <= S_PLAY;
            beat_left <= word_dur;
            beat_cnt  <= '0;
            half_cnt  <= '0;
            buzzer_o  <= (word_hp != 9'd0);
          end
        end

        S_PLAY: begin
          if (tick) begin
            beat_cnt <= beat_cnt_nxt;

            if ((note_hp != 9'd0) && (half_cnt == note_hp - 9'd1)) begin
              half_cnt <= '0;
              if (!in_gap) buzzer_o <= ~buzzer_o;
            end else begin
              half_cnt <= half_cnt + 9'd1;
            end
            if (in_gap) buzzer_o <= 1'b0;

            if (last_beat_tick) begin
              beat_left <= beat_left - 3'd1;
              if (beat_left == 3'd1) begin
                buzzer_o <= 1'b0;
                // The table does not wrap: running off the last entry
                // behaves like hitting an end marker.
                if (&bram.bram_addr) begin
                  state <= S_END;
                end else begin
                  bram.bram_addr <= bram.bram_addr + ADDR_WIDTH'(1);
                  bram.bram_en   <= 1'b1;
                  state          <= S_FETCH;
                end
              end
            end
          end
        end

        S_END: begin
          if (loop_en) begin
            bram.bram_addr <= '0;
            bram.bram_en   <= 1'b1;
            state          <= S_FETCH;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/buzzer_player.md
Name: buzzer_player

Overview:
- Sequencer directly upstream of the buzzer music BRAM.
- Walks the song table by driving the BRAM read port and decodes each 12-bit note word.
- Produces the square-wave buzzer output, holding each pitch for its coded duration.
- Started and stopped by single-cycle pulses from the APB-side control register; reports busy/done back to it.

Parameters:
- ADDR_WIDTH, 11, song table address width; must match the BRAM.
- DATA_WIDTH, 12, note word width; fixed at 12, other values unsupported.
- TICK_DIV, 500, clk cycles per time tick (10 us at 50 MHz).
- BEAT_TICKS, 12500, ticks per beat (125 ms).
- GAP_TICKS, 1000, silent ticks at the end of each note; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin playback at address 0.
- stop  in  1  one-cycle pulse; abort playback.
- loop_en  in  1  level; restart at address 0 on end of song.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_WIDTH  BRAM read address.
- bram_data  in  DATA_WIDTH  BRAM read data, valid one cycle after bram_en.
- buzzer_o  out  1  square wave to buzzer pin.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the song ends without looping.

Behaviour:
- Note word fields:
  - [11:9] dur = beats, 1..7; dur=0 is the end-of-song marker.
  - [8:0] hp = half-period in ticks; hp=0 is a rest (buzzer_o held 0).
- Reset values: bram_en=0, bram_addr=0, buzzer_o=0, busy=0, done=0; FSM in IDLE; all counters 0.
- Tick prescaler: free-running while busy; 1-cycle tick pulse every TICK_DIV cycles; cleared in IDLE and at each note load.
- States:
  - IDLE: start -> FETCH with addr=0.
  - FETCH: bram_en=1 for exactly 1 cycle at bram_addr -> LATCH.
  - LATCH: capture bram_data into note register. dur=0 -> END; else -> PLAY with beat_left=dur, beat_cnt=0, half_cnt=0, buzzer_o = (hp!=0).
  - PLAY:
    - On each tick, half_cnt increments.
    - When half_cnt==hp-1 and hp!=0: toggle buzzer_o, half_cnt=0.
    - On each tick, beat_cnt increments; at BEAT_TICKS-1 it clears and beat_left decrements.
    - When beat_left reaches 0: buzzer_o=0; if bram_addr is all ones -> END, else addr+1 -> FETCH.
  - END: loop_en=1 -> addr=0, FETCH; else done=1 for 1 cycle -> IDLE.
- Fixed 2-cycle silent inter-note gap (FETCH+LATCH); buzzer_o=0 in FETCH, LATCH, END, IDLE.
- Address does not wrap: the last table entry is treated as followed by an end marker (honours loop_en).
- start while busy: ignored.
- stop in any state: next cycle IDLE, buzzer_o=0, bram_en=0, no done pulse. stop+start in the same cycle: stop wins.
- Widths: beat_cnt sized for BEAT_TICKS, half_cnt 9 bits, prescaler sized for TICK_DIV; all compares unsigned.

Optional Feature:
- Macro: BUZZER_PLAYER_GAP_EN.
- Defined: during PLAY, when beat_left==1 and beat_cnt >= BEAT_TICKS-GAP_TICKS, buzzer_o is forced 0 and the toggle is suppressed (articulation gap). Total note length is unchanged. GAP_TICKS must be < BEAT_TICKS.
- Undefined: no gap logic; GAP_TICKS is ignored.

Test Plan:
- Common setup: TICK_DIV=2, BEAT_TICKS=8; table 0x203, 0x400, 0x000. start -> bram_en pulses at addr 0; note 0 playback:
  - buzzer_o=1 for 6 clk, 0 for 6, 1 for 4.
  - Then 2-cycle gap.
  - addr 1 rest: buzzer_o=0 for 32 clk.
  - addr 2 marker: done pulses once, busy falls the same cycle IDLE is entered.
- Same table, loop_en=1 -> after the addr 2 marker, bram_addr returns to 0; no done; pattern repeats identically.
- stop mid-note 0 (cycle 5 of PLAY) -> next cycle buzzer_o=0, busy=0; a later start replays from addr 0.
- start pulsed during PLAY -> ignored, bram_addr unchanged; start+stop together from IDLE -> stays IDLE.
- ADDR_WIDTH=2, table 0x201 in all 4 entries, loop_en=0 -> 4 notes then done; no fetch beyond addr 3. rst asserted mid-PLAY -> all outputs at reset values on the next cycle.
- With BUZZER_PLAYER_GAP_EN, GAP_TICKS=2, note 0x201 -> buzzer_o toggles every 2 clk for 12 clk, then 0 for the final 4 clk.
